// File: rtl/input_conditioner.sv
// Multi-channel board-input front end: synchroniser, optional inversion, debounce,
// registered edge pulses and optional hold-to-repeat, one independent slice per channel.
module input_conditioner #(
    parameter int           N               = 4,
    parameter int           SYNC_STAGES     = 2,
    parameter int           DEBOUNCE_CYCLES = 500000,
    parameter logic [N-1:0] INVERT          = '0,
    parameter logic [N-1:0] REPEAT_EN       = '0,
    parameter int           REPEAT_DELAY    = 25000000,
    parameter int           REPEAT_RATE     = 5000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] raw,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] held
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REPEAT
    } rep_state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DW-1:0]          r_dcnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        rep_state_t             r_state;
        rep_state_t             w_state_nxt;
        logic [RW-1:0]          r_rcnt;
        logic [RW-1:0]          w_rcnt_nxt;
        logic                   w_s;
        logic                   w_settle;
        logic                   w_deb_rise;
        logic                   w_deb_fall;
        logic                   w_rep_pulse;

        // A level change is due when the disagreement has lasted DEBOUNCE_CYCLES edges
        assign w_s        = r_sync[SYNC_STAGES-1] ^ INVERT[g];
        assign w_settle   = (w_s != r_level) && (r_dcnt == DEB_LAST);
        assign w_deb_rise = w_settle && w_s;
        assign w_deb_fall = w_settle && !w_s;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_sync  <= {SYNC_STAGES{INVERT[g]}};
                r_dcnt  <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], raw[g]};
                if ((w_s == r_level) || w_settle) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
                if (w_settle) begin
                    r_level <= w_s;
                end
                r_rise  <= w_deb_rise || w_rep_pulse;
                r_fall  <= w_deb_fall;
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
            end
        end

        // Debounced fall always wins over a repeat that would land on the same edge
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_rep_pulse = 1'b0;
            if (REPEAT_EN[g]) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_deb_rise) begin
                            w_state_nxt = ST_ARMED;
                            w_rcnt_nxt  = '0;
                        end
                    end
                    ST_ARMED: begin
                        if (w_deb_fall) begin
                            w_state_nxt = ST_IDLE;
                            w_rcnt_nxt  = '0;
                        end else if (r_rcnt == DELAY_LAST) begin
                            w_rep_pulse = 1'b1;
                            w_state_nxt = ST_REPEAT;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_deb_fall) begin
                            w_state_nxt = ST_IDLE;
                            w_rcnt_nxt  = '0;
                        end else if (r_rcnt == RATE_LAST) begin
                            w_rep_pulse = 1'b1;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign level[g] = r_level;
        assign rise[g]  = r_rise;
        assign fall[g]  = r_fall;
        assign held[g]  = (r_state == ST_REPEAT);
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised, multi-channel front end for board inputs (pushbuttons and slide switches). It replaces the single-channel debouncer that feeds the CPU reset and key inputs.
- Each channel performs, in order:
  - metastability synchronisation
  - optional polarity inversion
  - debounce
  - edge detection
  - optional hold-to-repeat
- Sits between the board pins and the CPU in the top level. One instance conditions KEY and SW together.

Parameters:
- N, 4: number of channels.
- SYNC_STAGES, 2: synchroniser flops per channel; minimum 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before `level` changes; minimum 1.
- INVERT, {N{1'b0}}: per-channel bit mask; 1 means the raw pin is active-low.
- REPEAT_EN, {N{1'b0}}: per-channel bit mask; 1 enables auto-repeat.
- REPEAT_DELAY, 25000000: cycles of continuous hold before the first repeat pulse.
- REPEAT_RATE, 5000000: cycles between subsequent repeat pulses.

Ports:
- clock, input, 1: system clock (CLOCK_50 domain).
- reset, input, 1: asynchronous, active-low reset.
- raw, input, N: unsynchronised pin levels.
- level, output, N: debounced, active-high channel state.
- rise, output, N: one-cycle pulse on debounced 0->1 edge, and on each repeat event.
- fall, output, N: one-cycle pulse on debounced 1->0 edge.
- held, output, N: high while the channel is in repeat phase (first repeat issued, still pressed).

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchroniser flops load INVERT[i], so the reset state is the inactive pin level.
  - level=0, rise=0, fall=0, held=0.
  - All counters cleared.
- Release is synchronous to clock. No output toggles during the first SYNC_STAGES cycles after release while raw is at its inactive level.
- Synchroniser: raw[i] shifts through SYNC_STAGES flops. s[i] = last stage XOR INVERT[i].
- Debounce counter, width clog2(DEBOUNCE_CYCLES+1), per channel:
  - If s[i]==level[i]: counter clears to 0.
  - Otherwise the counter increments.
  - When it would reach DEBOUNCE_CYCLES, on that edge: level[i] <= s[i], counter clears.
  - Any single-cycle return of s to level restarts the count.
  - DEBOUNCE_CYCLES=1 means level follows s with one-cycle delay.
- Latency: a clean raw transition reaches level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Edges: rise/fall are registered and assert in the same cycle level changes, for exactly one cycle. rise and fall are never both 1 on a channel.
- Repeat FSM, per channel, only when REPEAT_EN[i]=1. States:
  - IDLE -> ARMED on debounced rise; repeat counter cleared.
  - ARMED: counter increments each cycle. When the count reaches REPEAT_DELAY: rise pulse, counter cleared, -> REPEAT, held=1.
  - REPEAT: counter increments. Each time it reaches REPEAT_RATE: rise pulse, counter cleared.
  - Debounced fall in ARMED or REPEAT -> IDLE, held=0 in the same cycle as fall, counter cleared.
- With REPEAT_EN[i]=0, held[i] stays 0 and rise occurs only on true edges.
- Repeat pulse and debounced edge cannot coincide: the counter is cleared on edges.
- Channels are fully independent. Simultaneous edges on multiple channels each produce their own pulses in the same cycle.
- Reset asserted mid-debounce or mid-repeat: all state is lost. No pulse is emitted on reset entry or exit.
- Counters saturate by construction (always cleared at their terminal count); no wrap-around is permitted.
- No combinational path from raw to any output.

Test Plan:
Bench parameters: N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, INVERT=4'b0111, REPEAT_EN=4'b0001, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset/inactive pins: raw=4'b0111, release reset.
  - level=0, rise=0, fall=0, held=0 for 50 cycles.
- Clean press on ch3 (active-high, no repeat): raw[3] 0->1 held for 40 cycles.
  - level[3] rises exactly 10 edges after sampling.
  - rise[3] pulses once for 1 cycle.
  - On release, fall[3] pulses once, 10 edges later; held[3] stays 0.
- Bounce on ch1: raw[1] toggles every 3 cycles for 30 cycles, then settles at 0.
  - No activity during the toggling.
  - level[1]=1 and a single rise[1] 10 edges after the last toggle.
- Repeat on ch0: raw[0]=0 held for 100 cycles.
  - rise[0] at T, T+20, T+25, T+30, ...; held[0] goes high at T+20.
  - On release: fall[0] pulses, held[0] drops the same cycle, no further rise.
- Mid-operation reset: ch0 in REPEAT state, assert reset for 3 cycles, keep raw[0]=0.
  - Outputs are 0 immediately (asynchronous).
  - After release: a fresh debounce yields rise[0] at 10 edges, then the first repeat 20 cycles later.
- Simultaneous: ch2 and ch3 pressed in the same cycle.
  - rise[2] and rise[3] are asserted together in one cycle.
